// File: rtl/ps2_key_emitter.sv
// ps2_key_emitter: device-side PS/2 set-2 transmitter for a single key.
// A press emits the make code; a release emits 0xF0 followed by the code latched at press.
// Each byte goes out as an 11-bit frame (start, 8 data LSB first, odd parity, stop),
// followed by an idle gap.
// Optional feature: define PS2_TYPEMATIC_EN to repeat the make code while the key is held.
module ps2_key_emitter #(
    parameter int unsigned CLK_DIV   = 2500,
    parameter int unsigned GAP_CYC   = 5000,
    parameter int unsigned TM_DELAY  = 25000000,
    parameter int unsigned TM_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_status,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       byte_done
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StStop,
        StGap
    } state_t;

    localparam int unsigned HW = $clog2(CLK_DIV + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    state_t        state;
    logic [HW-1:0] half_cnt;
    logic          half_phase;  // 0: ps2_clk high half, 1: low half
    logic [3:0]    bit_idx;
    logic [GW-1:0] gap_cnt;
    logic [10:0]   frame_sr;    // bit 0 is the bit currently on ps2_data
    logic          reported;    // last key state actually sent (1 = down)
    logic [7:0]    rcode;       // code latched at press, reused for break and repeats
    logic          pend;        // second byte of a break (rcode) still to send

    // Frame layout, LSB first on the wire: start 0, data, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

`ifdef PS2_TYPEMATIC_EN
    localparam int unsigned TM_MAX = (TM_DELAY > TM_PERIOD) ? TM_DELAY : TM_PERIOD;
    localparam int unsigned TW     = $clog2(TM_MAX + 1);

    logic [TW-1:0] tm_cnt;
    logic          tm_rep;   // first repeat already sent for this press
    logic          tm_fire;

    // Repeat is due on the last cycle of the current interval while the key is held
    always_comb begin
        tm_fire = reported &&
                  (tm_cnt == (tm_rep ? TW'(TM_PERIOD - 1) : TW'(TM_DELAY - 1)));
    end
`else
    logic unused_tm;
    assign unused_tm = ^{TM_DELAY, TM_PERIOD};
`endif

    // Main sequencer: key-level comparison, frame bit timing, gap and byte queue
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= StIdle;
            half_cnt   <= '0;
            half_phase <= 1'b0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            frame_sr   <= '0;
            reported   <= 1'b0;
            rcode      <= '0;
            pend       <= 1'b0;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
`ifdef PS2_TYPEMATIC_EN
            tm_cnt     <= '0;
            tm_rep     <= 1'b0;
`endif
        end else begin
            byte_done <= 1'b0;
`ifdef PS2_TYPEMATIC_EN
            // Held-key timer only runs while idle with the key reported down and nothing due
            if (state == StIdle && reported && key_status && !tm_fire) begin
                tm_cnt <= tm_cnt + TW'(1);
            end else begin
                tm_cnt <= '0;
            end
`endif
            unique case (state)
                StIdle: begin
                    // A release always wins over a repeat due in the same cycle
                    if (key_status != reported) begin
                        reported   <= key_status;
                        busy       <= 1'b1;
                        state      <= StStart;
                        ps2_data   <= 1'b0;
                        ps2_clk    <= 1'b1;
                        half_cnt   <= '0;
                        half_phase <= 1'b0;
                        bit_idx    <= '0;
                        if (key_status) begin
                            rcode    <= key_code;
                            frame_sr <= frame_of(key_code);
                            pend     <= 1'b0;
`ifdef PS2_TYPEMATIC_EN
                            tm_rep   <= 1'b0;
`endif
                        end else begin
                            frame_sr <= frame_of(8'hF0);
                            pend     <= 1'b1;
                        end
                    end
`ifdef PS2_TYPEMATIC_EN
                    else if (tm_fire) begin
                        busy       <= 1'b1;
                        state      <= StStart;
                        ps2_data   <= 1'b0;
                        ps2_clk    <= 1'b1;
                        half_cnt   <= '0;
                        half_phase <= 1'b0;
                        bit_idx    <= '0;
                        frame_sr   <= frame_of(rcode);
                        pend       <= 1'b0;
                        tm_rep     <= 1'b1;
                    end
`endif
                end

                StStart, StShift, StStop: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt   <= '0;
                        half_phase <= ~half_phase;
                        if (!half_phase) begin
                            ps2_clk <= 1'b0;
                        end else begin
                            ps2_clk <= 1'b1;
                            if (bit_idx == 4'd10) begin
                                state     <= StGap;
                                ps2_data  <= 1'b1;
                                byte_done <= 1'b1;
                                gap_cnt   <= '0;
                            end else begin
                                bit_idx  <= bit_idx + 4'd1;
                                frame_sr <= frame_sr >> 1;
                                ps2_data <= frame_sr[1];
                                state    <= (bit_idx == 4'd9) ? StStop : StShift;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end

                StGap: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (pend) begin
                            pend       <= 1'b0;
                            state      <= StStart;
                            ps2_data   <= 1'b0;
                            ps2_clk    <= 1'b1;
                            half_cnt   <= '0;
                            half_phase <= 1'b0;
                            bit_idx    <= '0;
                            frame_sr   <= frame_of(rcode);
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_emitter.sv
// Directed bench for ps2_key_emitter (CLK_DIV=4, GAP_CYC=8, TM_DELAY=200, TM_PERIOD=100).
// Define PS2_TYPEMATIC_EN for both files to exercise the repeat path.
module tb_ps2_key_emitter;

    logic       clk;
    logic       rst;
    logic [7:0] key_code;
    logic       key_status;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       byte_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_base;

    // Hand-built frames {stop, parity, data[7:0], start}
    localparam logic [10:0] F_1C = 11'b1_0_00011100_0;
    localparam logic [10:0] F_F0 = 11'b1_1_11110000_0;

    ps2_key_emitter #(
        .CLK_DIV  (4),
        .GAP_CYC  (8),
        .TM_DELAY (200),
        .TM_PERIOD(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_status(key_status),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .busy      (busy),
        .byte_done (byte_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (byte_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts on the first cycle of a frame; ends on the gap-entry cycle.
    // drop_at >= 0 lowers key_status at that cycle of the frame.
    task automatic expect_frame(input logic [10:0] f, input string tag, input int drop_at);
        logic [1:0] exp;
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < 8; c++) begin
                exp = {(c < 4) ? 1'b1 : 1'b0, f[i]};
                check($sformatf("%s b%0d c%0d clk/data", tag, i, c),
                      {30'b0, ps2_clk, ps2_data}, {30'b0, exp});
                if (i * 8 + c == drop_at) key_status = 1'b0;
                tick();
            end
        end
        check({tag, " byte_done"}, {31'b0, byte_done}, 32'd1);
        check({tag, " gap lines"}, {30'b0, ps2_clk, ps2_data}, 32'd3);
    endtask

    // From gap entry, checks the remaining gap cycles and steps onto the cycle after the gap
    task automatic expect_gap(input string tag);
        for (int j = 1; j < 8; j++) begin
            tick();
            check($sformatf("%s gap%0d", tag, j),
                  {29'b0, busy, byte_done, ps2_clk, ps2_data}, 32'b1011);
        end
        tick();
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s idle%0d", tag, j),
                  {29'b0, busy, byte_done, ps2_clk, ps2_data}, 32'b0011);
            tick();
        end
    endtask

    initial begin
        rst        = 1'b0;
        key_code   = 8'h00;
        key_status = 1'b0;
        tick();
        tick();
        check("reset ps2_clk", {31'b0, ps2_clk}, 32'd1);
        check("reset ps2_data", {31'b0, ps2_data}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset byte_done", {31'b0, byte_done}, 32'd0);
        rst = 1'b1;
        tick();
        expect_idle("post_reset", 5);

        // Press 0x1C: single make frame
        done_base  = done_cnt;
        key_code   = 8'h1C;
        key_status = 1'b1;
        tick();
        expect_frame(F_1C, "make", -1);
        expect_gap("make");
        check("make busy end", {31'b0, busy}, 32'd0);
        check("make done count", done_cnt - done_base, 32'd1);

        // Release: 0xF0 then 0x1C
        done_base  = done_cnt;
        key_status = 1'b0;
        tick();
        expect_frame(F_F0, "brk_f0", -1);
        expect_gap("brk_f0");
        expect_frame(F_1C, "brk_1c", -1);
        expect_gap("brk_1c");
        check("brk busy end", {31'b0, busy}, 32'd0);
        check("brk done count", done_cnt - done_base, 32'd2);
        expect_idle("after_brk", 4);

        // Press 0x1C, change key_code while held; break still uses 0x1C
        key_code   = 8'h1C;
        key_status = 1'b1;
        tick();
        key_code = 8'h23;
        expect_frame(F_1C, "make2", -1);
        expect_gap("make2");
        check("make2 busy end", {31'b0, busy}, 32'd0);
        done_base  = done_cnt;
        key_status = 1'b0;
        tick();
        // Press then release again inside the 0xF0 frame: must net to nothing
        key_status = 1'b1;
        expect_frame(F_F0, "brk2_f0", 40);
        expect_gap("brk2_f0");
        expect_frame(F_1C, "brk2_1c", -1);
        expect_gap("brk2_1c");
        check("brk2 done count", done_cnt - done_base, 32'd2);
        expect_idle("no_extra", 30);

        // Reset in the middle of the data bits aborts the frame
        key_code   = 8'h1C;
        key_status = 1'b1;
        tick();
        for (int j = 0; j < 20; j++) tick();
        check("midframe busy", {31'b0, busy}, 32'd1);
        rst        = 1'b0;
        key_status = 1'b0;
        tick();
        check("abort lines", {30'b0, ps2_clk, ps2_data}, 32'd3);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort byte_done", {31'b0, byte_done}, 32'd0);
        rst = 1'b1;
        tick();
        expect_idle("after_abort", 5);
        key_status = 1'b1;
        tick();
        expect_frame(F_1C, "restart", -1);
        expect_gap("restart");
        check("restart busy end", {31'b0, busy}, 32'd0);

`ifdef PS2_TYPEMATIC_EN
        // Held key: first repeat 200 cycles after idle entry, then every 100
        expect_idle("tm_delay", 200);
        expect_frame(F_1C, "tm_rep1", -1);
        expect_gap("tm_rep1");
        expect_idle("tm_per1", 100);
        expect_frame(F_1C, "tm_rep2", -1);
        expect_gap("tm_rep2");
        expect_idle("tm_per2", 100);
        expect_frame(F_1C, "tm_rep3", -1);
        expect_gap("tm_rep3");
`else
        // Held key without typematic: no further frames
        expect_idle("no_repeat", 250);
`endif
        key_status = 1'b0;
        tick();
        expect_frame(F_F0, "final_f0", -1);
        expect_gap("final_f0");
        expect_frame(F_1C, "final_1c", -1);
        expect_gap("final_1c");
        check("final busy end", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
